// File: rtl/mmc1_serial_loader.sv
// MMC1 serial register port: five single-bit writes assemble a 5-bit value that
// is committed to CTRL/CHR0/CHR1/PRG, with D7 reset writes and back-to-back filtering.
module mmc1_serial_loader #(
  parameter logic [4:0] CTRL_RESET_VAL = 5'b01100
) (
  input  logic       CPU_M2,
  input  logic       nRESET,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D7,
  input  logic       CPU_D0,
  output logic [4:0] CTRL,
  output logic [4:0] CHR0,
  output logic [4:0] CHR1,
  output logic [4:0] PRG,
  output logic [2:0] SHIFT_CNT,
  output logic       COMMIT,
  output logic [1:0] COMMIT_SEL
);

  // State encoding doubles as the count of collected bits.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] shift_reg, shift_next;
  logic       prev_wr_reg, prev_wr_next;
  logic [4:0] ctrl_reg, ctrl_next;
  logic [4:0] chr0_reg, chr0_next;
  logic [4:0] chr1_reg, chr1_next;
  logic [4:0] prg_reg, prg_next;
  logic       commit_reg, commit_next;
  logic [1:0] commit_sel_reg, commit_sel_next;

  logic       wr;
  logic [1:0] sel;
  logic [4:0] load_val;

  assign wr       = !nCPU_ROMSEL && !nCPU_RW;
  assign sel      = {CPU_A14, CPU_A13};
  assign load_val = {CPU_D0, shift_reg};

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    prev_wr_next    = wr;
    ctrl_next       = ctrl_reg;
    chr0_next       = chr0_reg;
    chr1_next       = chr1_reg;
    prg_next        = prg_reg;
    commit_next     = 1'b0;
    commit_sel_next = commit_sel_reg;

    if (wr && CPU_D7) begin
      state_next = IDLE;
      shift_next = 4'd0;
      ctrl_next  = ctrl_reg | CTRL_RESET_VAL;
    end else if (wr && !prev_wr_reg) begin
      case (state_reg)
        IDLE: begin
          state_next = S1;
          shift_next = {CPU_D0, shift_reg[3:1]};
        end
        S1: begin
          state_next = S2;
          shift_next = {CPU_D0, shift_reg[3:1]};
        end
        S2: begin
          state_next = S3;
          shift_next = {CPU_D0, shift_reg[3:1]};
        end
        S3: begin
          state_next = S4;
          shift_next = {CPU_D0, shift_reg[3:1]};
        end
        S4: begin
          // Only the fifth write's address picks the destination register.
          case (sel)
            2'b00:   ctrl_next = load_val;
            2'b01:   chr0_next = load_val;
            2'b10:   chr1_next = load_val;
            default: prg_next  = load_val;
          endcase
          state_next      = IDLE;
          shift_next      = 4'd0;
          commit_next     = 1'b1;
          commit_sel_next = sel;
        end
        default: begin
          state_next = IDLE;
          shift_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(negedge CPU_M2) begin
    if (!nRESET) begin
      state_reg      <= IDLE;
      shift_reg      <= 4'd0;
      prev_wr_reg    <= 1'b0;
      ctrl_reg       <= CTRL_RESET_VAL;
      chr0_reg       <= 5'd0;
      chr1_reg       <= 5'd0;
      prg_reg        <= 5'd0;
      commit_reg     <= 1'b0;
      commit_sel_reg <= 2'd0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      prev_wr_reg    <= prev_wr_next;
      ctrl_reg       <= ctrl_next;
      chr0_reg       <= chr0_next;
      chr1_reg       <= chr1_next;
      prg_reg        <= prg_next;
      commit_reg     <= commit_next;
      commit_sel_reg <= commit_sel_next;
    end
  end

  assign CTRL       = ctrl_reg;
  assign CHR0       = chr0_reg;
  assign CHR1       = chr1_reg;
  assign PRG        = prg_reg;
  assign SHIFT_CNT  = state_reg;
  assign COMMIT     = commit_reg;
  assign COMMIT_SEL = commit_sel_reg;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Bench for mmc1_serial_loader: queue-based protocol model compared every cycle,
// plus hand-computed literal checks at the key points of each scenario.
module tb_mmc1_serial_loader;

  logic       CPU_M2 = 1'b0;
  logic       nRESET = 1'b0;
  logic       nCPU_ROMSEL = 1'b1;
  logic       nCPU_RW = 1'b1;
  logic       CPU_A14 = 1'b0;
  logic       CPU_A13 = 1'b0;
  logic       CPU_D7 = 1'b0;
  logic       CPU_D0 = 1'b0;
  logic [4:0] CTRL, CHR0, CHR1, PRG;
  logic [2:0] SHIFT_CNT;
  logic       COMMIT;
  logic [1:0] COMMIT_SEL;

  mmc1_serial_loader dut (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D7(CPU_D7), .CPU_D0(CPU_D0),
    .CTRL(CTRL), .CHR0(CHR0), .CHR1(CHR1), .PRG(PRG),
    .SHIFT_CNT(SHIFT_CNT), .COMMIT(COMMIT), .COMMIT_SEL(COMMIT_SEL)
  );

  always #5 CPU_M2 = ~CPU_M2;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: collected bits in write order, registers indexed by {A14,A13}.
  bit         m_bits[$];
  logic [4:0] m_bank[4];
  bit         m_prev;
  bit         m_commit;
  logic [1:0] m_sel;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit rom_n, input bit rw_n,
                            input logic [1:0] a, input bit d7, input bit d0);
    bit wr;
    logic [4:0] v;
    if (!rst) begin
      m_bits.delete();
      m_bank[0] = 5'b01100;
      m_bank[1] = 5'd0;
      m_bank[2] = 5'd0;
      m_bank[3] = 5'd0;
      m_prev = 1'b0;
      m_commit = 1'b0;
      m_sel = 2'd0;
      return;
    end
    wr = !rom_n && !rw_n;
    m_commit = 1'b0;
    if (wr && d7) begin
      m_bits.delete();
      m_bank[0] = m_bank[0] | 5'b01100;
    end else if (wr && !m_prev) begin
      m_bits.push_back(d0);
      if (m_bits.size() == 5) begin
        v = 5'd0;
        for (int i = 0; i < 5; i++) v[i] = m_bits[i];
        m_bank[a] = v;
        m_commit = 1'b1;
        m_sel = a;
        m_bits.delete();
      end
    end
    m_prev = wr;
  endtask

  // Outputs are stable for the whole cycle; sample on the rising edge.
  always @(posedge CPU_M2) begin
    if (check_en) begin
      chk("ctrl", CTRL, m_bank[0]);
      chk("chr0", CHR0, m_bank[1]);
      chk("chr1", CHR1, m_bank[2]);
      chk("prg", PRG, m_bank[3]);
      chk("shift_cnt", {2'b00, SHIFT_CNT}, 5'(m_bits.size()));
      chk("commit", {4'd0, COMMIT}, {4'd0, m_commit});
      chk("commit_sel", {3'd0, COMMIT_SEL}, {3'd0, m_sel});
    end
  end

  task automatic cyc(input bit rst, input bit rom_n, input bit rw_n,
                     input logic [1:0] a, input bit d7, input bit d0);
    @(posedge CPU_M2);
    nRESET = rst; nCPU_ROMSEL = rom_n; nCPU_RW = rw_n;
    CPU_A14 = a[1]; CPU_A13 = a[0]; CPU_D7 = d7; CPU_D0 = d0;
    @(negedge CPU_M2);
    model_step(rst, rom_n, rw_n, a, d7, d0);
    #1;
    $display("cyc t=%0t rst=%0b wr=%0b a=%0d d7=%0b d0=%0b -> ctrl=%b chr0=%b chr1=%b prg=%b cnt=%0d commit=%0b sel=%0d",
             $time, rst, !rom_n && !rw_n, a, d7, d0, CTRL, CHR0, CHR1, PRG, SHIFT_CNT, COMMIT, COMMIT_SEL);
  endtask

  task automatic idle();                            cyc(1, 1, 1, 2'd0, 0, 0); endtask
  task automatic wr(input logic [1:0] a, input bit d0); cyc(1, 0, 0, a, 0, d0); endtask
  task automatic d7w();                             cyc(1, 0, 0, 2'd0, 1, 0); endtask
  task automatic rd();                              cyc(1, 0, 1, 2'd3, 0, 1); endtask
  task automatic w6000(input bit d0);               cyc(1, 1, 0, 2'd3, 0, d0); endtask

  task automatic spaced(input logic [1:0] a, input bit d0);
    wr(a, d0);
    idle();
  endtask

  initial begin
    // Reset held for two cycles
    cyc(0, 1, 1, 2'd0, 0, 0);
    cyc(0, 1, 1, 2'd0, 0, 0);
    check_en = 1'b1;
    chk("rst_ctrl", CTRL, 5'b01100);
    chk("rst_chr0", CHR0, 5'd0);
    chk("rst_chr1", CHR1, 5'd0);
    chk("rst_prg", PRG, 5'd0);
    chk("rst_cnt", {2'b00, SHIFT_CNT}, 5'd0);
    chk("rst_commit", {4'd0, COMMIT}, 5'd0);
    idle();

    // PRG load via $E000: 1,0,1,1,0
    spaced(2'd3, 1); spaced(2'd3, 0); spaced(2'd3, 1); spaced(2'd3, 1);
    wr(2'd3, 0);
    chk("prg_load", PRG, 5'b01101);
    chk("prg_commit", {4'd0, COMMIT}, 5'd1);
    chk("prg_sel", {3'd0, COMMIT_SEL}, 5'd3);
    chk("prg_ctrl_kept", CTRL, 5'b01100);
    idle();
    chk("prg_commit_fall", {4'd0, COMMIT}, 5'd0);

    // Back-to-back filter, then CHR0 via $A000
    wr(2'd1, 1); wr(2'd1, 0);
    chk("filter_cnt", {2'b00, SHIFT_CNT}, 5'd1);
    idle();
    spaced(2'd1, 0); spaced(2'd1, 1); spaced(2'd1, 1);
    wr(2'd1, 1);
    chk("chr0_load", CHR0, 5'b11101);
    chk("chr0_sel", {3'd0, COMMIT_SEL}, 5'd1);
    idle();

    // CHR1: early writes addressed elsewhere, fifth to $C000
    spaced(2'd0, 1); spaced(2'd3, 0); spaced(2'd1, 0); spaced(2'd0, 1);
    wr(2'd2, 1);
    chk("chr1_load", CHR1, 5'b11001);
    chk("chr1_chr0_kept", CHR0, 5'b11101);
    idle();

    // D7 mid-sequence
    spaced(2'd0, 1); spaced(2'd0, 0); spaced(2'd0, 1);
    d7w();
    chk("d7_cnt", {2'b00, SHIFT_CNT}, 5'd0);
    chk("d7_ctrl", CTRL, 5'b01100);
    chk("d7_commit", {4'd0, COMMIT}, 5'd0);
    idle();

    // CTRL preload 00011, then D7 right after a data write
    spaced(2'd0, 1); spaced(2'd0, 1); spaced(2'd0, 0); spaced(2'd0, 0);
    wr(2'd0, 0);
    chk("ctrl_preload", CTRL, 5'b00011);
    idle();
    wr(2'd0, 1);
    d7w();
    chk("d7b2b_ctrl", CTRL, 5'b01111);
    chk("d7b2b_cnt", {2'b00, SHIFT_CNT}, 5'd0);
    idle();

    // nRESET mid-sequence
    spaced(2'd3, 1); spaced(2'd3, 1); spaced(2'd3, 1); spaced(2'd3, 1);
    cyc(0, 0, 0, 2'd3, 0, 1);
    chk("midrst_prg", PRG, 5'd0);
    chk("midrst_ctrl", CTRL, 5'b01100);
    wr(2'd3, 1);
    chk("midrst_cnt", {2'b00, SHIFT_CNT}, 5'd1);
    chk("midrst_commit", {4'd0, COMMIT}, 5'd0);

    // Reads and $6000 writes change nothing but break back-to-back
    rd(); w6000(1); rd();
    chk("rd_cnt", {2'b00, SHIFT_CNT}, 5'd1);
    wr(2'd3, 0);
    w6000(0);
    wr(2'd3, 1);
    chk("gap_cnt", {2'b00, SHIFT_CNT}, 5'd3);
    idle(); idle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
